mvd_eg_dec: RTL

- Decoder-side counterpart of the MVD cost/difference logic in the rec_mc path.
- Consumes a serial bitstream holding one signed Exp-Golomb (order 0, se(v)) code for mvd_x, then one for mvd_y.
- Reconstructs mv = mvp + mvd with saturation to the FMV range.
- Used by the bitstream-check/decode loopback to confirm that the MVDs chosen by the encoder round-trip to the original MVs.

---
 rtl/mvd_eg_dec_pkg.sv | 26 ++
 rtl/mvd_eg_dec_clip.sv | 28 ++
 rtl/mvd_eg_dec_unmap.sv | 20 ++
 rtl/mvd_eg_dec.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mvd_eg_dec_pkg.sv
// mvd_eg_dec_pkg: shared state encoding for the
// signed Exp-Golomb MVD decoder.
package mvd_eg_dec_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_X_PRE,
    S_X_SUF,
    S_Y_PRE,
    S_Y_SUF,
    S_ADD
  } state_t;

  function automatic logic is_pre(state_t s);
    return (s == S_X_PRE) || (s == S_Y_PRE);
  endfunction

  function automatic logic is_suf(state_t s);
    return (s == S_X_SUF) || (s == S_Y_SUF);
  endfunction

  function automatic logic is_y(state_t s);
    return (s == S_Y_PRE) || (s == S_Y_SUF);
  endfunction

endpackage

// File: rtl/mvd_eg_dec_clip.sv
// clip_add: signed a + b, clamped to the FW-bit
// signed range, with a flag when clamping happened.
module clip_add #(
  parameter int FW = 10,
  parameter int DW = 11
) (
  input  logic [FW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [FW-1:0] y,
  output logic          sat
);

  logic [FW+1:0] sum;

  // In range iff the top three sum bits agree
  always_comb begin
    sum = {{2{a[FW-1]}}, a}
        + {{(FW+2-DW){b[DW-1]}}, b};
    sat = !((sum[FW+1:FW-1] == 3'b000) ||
            (sum[FW+1:FW-1] == 3'b111));
    y = sum[FW-1:0];
    if (sat) begin
      y = sum[FW+1] ? {1'b1, {(FW-1){1'b0}}}
                    : {1'b0, {(FW-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mvd_eg_dec_unmap.sv
// eg_se_unmap: codeNum -> signed MVD (se(v) mapping).
// Odd codes are positive, even codes negative.
module eg_se_unmap #(
  parameter int W = 11
) (
  input  logic [W:0]   code_num,
  output logic [W-1:0] mvd
);

  logic [W-1:0] half;

  assign half = code_num[W:1];

  // Odd: +(c+1)/2 == half+1; even: -(c/2) == -half
  always_comb begin
    if (code_num[0]) mvd = half + {{(W-1){1'b0}}, 1'b1};
    else             mvd = -half;
  end

endmodule

// File: rtl/mvd_eg_dec.sv
// mvd_eg_dec: serial se(v) decode of mvd_x/mvd_y, mv = sat(mvp + mvd).
// Optional MVD_EG_DEC_BITCNT_EN adds bits_cnt_o (total code bits).
module mvd_eg_dec
  import mvd_eg_dec_pkg::*;
#(
  parameter int FMV_WIDTH = 10,
  parameter int MVD_WIDTH = 11,
  parameter int MAX_LZ    = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [2*FMV_WIDTH-1:0] mvp_i,
  input  logic                   bit_i,
  input  logic                   bit_val_i,
  output logic                   bit_rdy_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [2*FMV_WIDTH-1:0] mv_o,
  output logic [2*MVD_WIDTH-1:0] mvd_o,
  output logic                   sat_o
`ifdef MVD_EG_DEC_BITCNT_EN
  ,
  output logic [6:0]             bits_cnt_o
`endif
);

  localparam int LZ_W = $clog2(MAX_LZ + 1);
  localparam logic [LZ_W-1:0] LZ_MAX = LZ_W'(MAX_LZ);
  localparam logic [LZ_W-1:0] LZ_ONE = LZ_W'(1);
  localparam logic [MAX_LZ:0] SH_ONE =
    {{MAX_LZ{1'b0}}, 1'b1};

  state_t state_q, state_d;

  logic [FMV_WIDTH-1:0] mvp_x_q, mvp_y_q;
  logic [LZ_W-1:0]      lz_q, cnt_q;
  logic [MAX_LZ-1:0]    shift_q;
  logic [MAX_LZ:0]      shift_nxt, code_num;
  logic [MVD_WIDTH-1:0] mvd_x_q, mvd_dec;
  logic [FMV_WIDTH-1:0] mv_x, mv_y;
  logic                 sat_x, sat_y;
  logic                 pre, suf, acc;
  logic                 code_end, y_end, lz_ovf;
  logic                 start_ok;

  assign pre = is_pre(state_q);
  assign suf = is_suf(state_q);
  assign acc = bit_val_i & (pre | suf);
  assign start_ok = (state_q == S_IDLE) & start_i;

  assign lz_ovf = acc & pre & ~bit_i
                & (lz_q == LZ_MAX);
  assign code_end = acc & (
    (pre & bit_i & (lz_q == '0)) |
    (suf & (cnt_q == LZ_ONE)));
  assign y_end = code_end & is_y(state_q);

  // The shift register only holds completed prefixes;
  // the final bit is folded in combinationally.
  assign shift_nxt = pre ? SH_ONE
                         : {shift_q, bit_i};
  assign code_num = shift_nxt - SH_ONE;

  eg_se_unmap #(
    .W(MVD_WIDTH)
  ) u_unmap (
    .code_num(code_num),
    .mvd     (mvd_dec)
  );

  clip_add #(
    .FW(FMV_WIDTH),
    .DW(MVD_WIDTH)
  ) u_add_x (
    .a  (mvp_x_q),
    .b  (mvd_x_q),
    .y  (mv_x),
    .sat(sat_x)
  );

  clip_add #(
    .FW(FMV_WIDTH),
    .DW(MVD_WIDTH)
  ) u_add_y (
    .a  (mvp_y_q),
    .b  (mvd_dec),
    .y  (mv_y),
    .sat(sat_y)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: x prefix/suffix, y prefix/suffix, ADD
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start_i) state_d = S_X_PRE;
      S_X_PRE:
        if (lz_ovf)             state_d = S_IDLE;
        else if (code_end)      state_d = S_Y_PRE;
        else if (acc && bit_i)  state_d = S_X_SUF;
      S_X_SUF:
        if (code_end) state_d = S_Y_PRE;
      S_Y_PRE:
        if (lz_ovf)             state_d = S_IDLE;
        else if (code_end)      state_d = S_ADD;
        else if (acc && bit_i)  state_d = S_Y_SUF;
      S_Y_SUF:
        if (code_end) state_d = S_ADD;
      S_ADD:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs from current state
  always_comb begin
    bit_rdy_o = pre | suf;
    busy_o    = (state_q != S_IDLE);
    done_o    = (state_q == S_ADD);
    err_o     = lz_ovf;
  end

  // Datapath; results land on the y-end edge so they
  // are already valid during the ADD/done cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mvp_x_q <= '0;
      mvp_y_q <= '0;
      lz_q    <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      mvd_x_q <= '0;
      mv_o    <= '0;
      mvd_o   <= '0;
      sat_o   <= 1'b0;
    end else begin
      if (start_ok) begin
        mvp_x_q <= mvp_i[FMV_WIDTH-1:0];
        mvp_y_q <= mvp_i[2*FMV_WIDTH-1:FMV_WIDTH];
        lz_q    <= '0;
        cnt_q   <= '0;
        shift_q <= '0;
      end
      if (acc) begin
        shift_q <= shift_nxt[MAX_LZ-1:0];
        if (pre && !bit_i) lz_q  <= lz_q + LZ_ONE;
        if (pre && bit_i)  cnt_q <= lz_q;
        if (suf)           cnt_q <= cnt_q - LZ_ONE;
      end
      if (code_end) begin
        lz_q <= '0;
        if (!is_y(state_q)) mvd_x_q <= mvd_dec;
      end
      if (y_end) begin
        mv_o  <= {mv_y, mv_x};
        mvd_o <= {mvd_x_q, mvd_dec};
        sat_o <= sat_x | sat_y;
      end
    end
  end

`ifdef MVD_EG_DEC_BITCNT_EN
  logic [6:0] bit_cnt_q;

  // Count accepted bits; publish alongside the result
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      bits_cnt_o <= '0;
    end else begin
      if (start_ok)  bit_cnt_q <= '0;
      else if (acc)  bit_cnt_q <= bit_cnt_q + 7'd1;
      if (y_end)     bits_cnt_o <= bit_cnt_q + 7'd1;
    end
  end
`endif

endmodule
